// File: rtl/hyperbus_rx_pkg.sv
// Shared types and constants for the HyperBus read-data assembler.
package hyperbus_rx_pkg;

  localparam int unsigned HW_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // FIFO entry is {last, data}; the packed struct itself lives in the user module.
  function automatic int unsigned entry_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/hyperbus_rx_fifo.sv
// Synchronous FIFO with a registered head word; a push into a full FIFO is
// accepted when the head is popped on the same edge.
module hyperbus_rx_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] entry_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             drop_c,
  output logic             empty_nxt_c
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  always_comb begin
    w_pop       = r_valid && ready_i;
    w_full      = (r_count == CNT_W'(DEPTH));
    w_push_ok   = push_i && (!w_full || w_pop);
    drop_c      = push_i && !w_push_ok;
    w_rd_nxt    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    empty_nxt_c = (w_count_nxt == '0);
    w_head_nxt  = r_head;
    // Head refills from the incoming word only when storage behind it is empty.
    if (r_count == CNT_W'(w_pop)) begin
      if (w_push_ok) w_head_nxt = entry_i;
    end else if (w_pop) begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= !empty_nxt_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= entry_i;
  end

  assign head_o  = r_head;
  assign valid_o = r_valid;

endmodule

// File: rtl/hyperbus_rx_assembler.sv
// Packs 16-bit DDR halfwords into DATA_WIDTH-bit read words and buffers them.
// Optional HYPERBUS_RX_ERR_CNT_EN adds a saturating dropped-word counter.
module hyperbus_rx_assembler
  import hyperbus_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BURST_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [BURST_W-1:0]    burst_len_i,
  input  logic                  ddr_valid_i,
  input  logic [HW_W-1:0]       ddr_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  overflow_o
`ifdef HYPERBUS_RX_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt_o
`endif
);
  localparam int unsigned HW_PER_WORD = DATA_WIDTH / HW_W;
  localparam int unsigned HC_W        = (HW_PER_WORD > 1) ? $clog2(HW_PER_WORD) : 1;
  localparam int unsigned ENTRY_W     = entry_w(DATA_WIDTH);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [BURST_W-1:0]    r_remaining;
  logic [BURST_W-1:0]    w_remaining_nxt;
  logic [HC_W-1:0]       r_hw_cnt;
  logic [HC_W-1:0]       w_hw_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] w_word_nxt;
  logic [DATA_WIDTH-1:0] w_word_c;
  logic                  r_overflow;
  logic                  w_overflow_nxt;
  logic                  r_busy;
  logic [HW_W-1:0]       w_hw;
  logic                  w_hw_last;
  logic                  w_push;
  entry_t                w_entry;
  entry_t                w_head;
  logic                  w_valid;
  logic                  w_drop;
  logic                  w_empty_nxt;

  // Rising-edge samples form the upper byte, falling-edge samples the lower.
  for (genvar g = 0; g < HW_W / 2; g++) begin : g_lane
    assign w_hw[HW_W/2 + g] = ddr_data_i[2*g+1];
    assign w_hw[g]          = ddr_data_i[2*g];
  end

  for (genvar g = 0; g < HW_PER_WORD; g++) begin : g_slice
    assign w_word_c[g*HW_W +: HW_W] = (r_hw_cnt == HC_W'(g)) ? w_hw : r_word[g*HW_W +: HW_W];
  end

  assign w_hw_last     = (r_hw_cnt == HC_W'(HW_PER_WORD - 1));
  assign w_push        = (r_state == RECV) && ddr_valid_i && w_hw_last;
  assign w_entry.last  = (r_remaining == BURST_W'(1));
  assign w_entry.data  = w_word_c;

  hyperbus_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_push),
    .entry_i     (w_entry),
    .ready_i     (ready_i),
    .head_o      (w_head),
    .valid_o     (w_valid),
    .drop_c      (w_drop),
    .empty_nxt_c (w_empty_nxt)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_hw_cnt_nxt    = r_hw_cnt;
    w_word_nxt      = r_word;
    w_overflow_nxt  = r_overflow;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_overflow_nxt = 1'b0;
          w_hw_cnt_nxt   = '0;
          if (burst_len_i != '0) begin
            w_remaining_nxt = burst_len_i;
            w_state_nxt     = RECV;
          end
        end
      end
      RECV: begin
        if (ddr_valid_i) begin
          w_word_nxt = w_word_c;
          if (w_hw_last) begin
            // A dropped word still counts, so the burst always terminates.
            w_hw_cnt_nxt    = '0;
            w_remaining_nxt = r_remaining - BURST_W'(1);
            if (w_drop) w_overflow_nxt = 1'b1;
            if (w_entry.last) w_state_nxt = w_empty_nxt ? IDLE : DRAIN;
          end else begin
            w_hw_cnt_nxt = r_hw_cnt + HC_W'(1);
          end
        end
      end
      DRAIN: begin
        if (w_empty_nxt) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_remaining <= '0;
      r_hw_cnt    <= '0;
      r_word      <= '0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_remaining <= w_remaining_nxt;
      r_hw_cnt    <= w_hw_cnt_nxt;
      r_word      <= w_word_nxt;
      r_overflow  <= w_overflow_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

`ifdef HYPERBUS_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              r_err_cnt <= '0;
    else if ((r_state == IDLE) && start_i)    r_err_cnt <= '0;
    else if (w_drop && (r_err_cnt != 8'hFF))  r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt_o = r_err_cnt;
`endif

  // last_o is qualified so a drained last word does not linger on the bus.
  assign data_o     = w_head.data;
  assign last_o     = w_head.last & w_valid;
  assign valid_o    = w_valid;
  assign busy_o     = r_busy;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_hyperbus_rx_assembler.sv
// Directed self-checking bench for hyperbus_rx_assembler (default 32-bit words, 4-deep FIFO).
module tb_hyperbus_rx_assembler;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] burst_len_i;
  logic        ddr_valid_i;
  logic [15:0] ddr_data_i;
  logic [31:0] data_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        overflow_o;
`ifdef HYPERBUS_RX_ERR_CNT_EN
  logic [7:0]  err_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hyperbus_rx_assembler #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .BURST_W    (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .burst_len_i (burst_len_i),
    .ddr_valid_i (ddr_valid_i),
    .ddr_data_i  (ddr_data_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o)
`ifdef HYPERBUS_RX_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Inverse lane mapping: hw[15:8] on odd (rising) bits, hw[7:0] on even bits.
  function automatic logic [15:0] to_ddr(input logic [15:0] hw);
    return {hw[15], hw[7], hw[14], hw[6], hw[13], hw[5], hw[12], hw[4],
            hw[11], hw[3], hw[10], hw[2], hw[9],  hw[1], hw[8],  hw[0]};
  endfunction

  task automatic send_raw(input logic [15:0] raw);
    ddr_valid_i = 1'b1;
    ddr_data_i  = raw;
    tick();
    ddr_valid_i = 1'b0;
    ddr_data_i  = 16'h0000;
  endtask

  task automatic start(input logic [15:0] len);
    start_i     = 1'b1;
    burst_len_i = len;
    tick();
    start_i     = 1'b0;
    burst_len_i = 16'h0000;
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    burst_len_i = 16'h0000;
    ddr_valid_i = 1'b0;
    ddr_data_i  = 16'h0000;
    ready_i     = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    check("por_valid", 32'(valid_o), 32'd0);
    check("por_busy",  32'(busy_o),  32'd0);
    check("por_data",  data_o,       32'h0);

    // 1: reset in the middle of a burst with a word waiting in the FIFO
    start(16'd3);
    check("t1_busy", 32'(busy_o), 32'd1);
    send_raw(to_ddr(16'hBEEF));
    send_raw(to_ddr(16'hCAFE));
    check("t1_valid_pre", 32'(valid_o), 32'd1);
    check("t1_data_pre",  data_o,       32'hCAFEBEEF);
    send_raw(to_ddr(16'h1234));
    #2 rst_ni = 1'b0;
    #1;
    check("t1_rst_valid", 32'(valid_o),    32'd0);
    check("t1_rst_last",  32'(last_o),     32'd0);
    check("t1_rst_busy",  32'(busy_o),     32'd0);
    check("t1_rst_ovf",   32'(overflow_o), 32'd0);
    check("t1_rst_data",  data_o,          32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("t1_post_valid", 32'(valid_o), 32'd0);
    check("t1_post_data",  data_o,       32'h0);

    // 2: raw lane bit mapping
    ready_i = 1'b1;
    start(16'd1);
    send_raw(16'hAAAA);
    check("t2_valid_mid", 32'(valid_o), 32'd0);
    send_raw(16'h5555);
    check("t2_valid", 32'(valid_o), 32'd1);
    check("t2_data",  data_o,       32'h00FFFF00);
    check("t2_last",  32'(last_o),  32'd1);
    tick();
    check("t2_valid_end", 32'(valid_o), 32'd0);
    check("t2_last_end",  32'(last_o),  32'd0);
    check("t2_busy_end",  32'(busy_o),  32'd0);
    check("t2_data_hold", data_o,       32'h00FFFF00);

    // 3: two words with gaps between halfwords
    start(16'd2);
    send_raw(to_ddr(16'h1111));
    tick();
    send_raw(to_ddr(16'h2222));
    check("t3_w0_valid", 32'(valid_o), 32'd1);
    check("t3_w0_data",  data_o,       32'h22221111);
    check("t3_w0_last",  32'(last_o),  32'd0);
    tick();
    check("t3_gap_valid", 32'(valid_o), 32'd0);
    check("t3_gap_busy",  32'(busy_o),  32'd1);
    tick();
    tick();
    send_raw(to_ddr(16'h3333));
    tick();
    tick();
    tick();
    send_raw(to_ddr(16'h4444));
    check("t3_w1_valid", 32'(valid_o), 32'd1);
    check("t3_w1_data",  data_o,       32'h44443333);
    check("t3_w1_last",  32'(last_o),  32'd1);
    tick();
    check("t3_end_valid", 32'(valid_o), 32'd0);
    check("t3_end_busy",  32'(busy_o),  32'd0);

    // 4: backpressure, words 5 and 6 dropped
    ready_i = 1'b0;
    start(16'd6);
    for (int k = 1; k <= 6; k++) begin
      send_raw(to_ddr(16'hA000 + 16'(k)));
      send_raw(to_ddr(16'hB000 + 16'(k)));
      if (k == 4) check("t4_ovf_at4", 32'(overflow_o), 32'd0);
      if (k == 5) check("t4_ovf_at5", 32'(overflow_o), 32'd1);
    end
    check("t4_busy_drain", 32'(busy_o), 32'd1);
    check("t4_head",       data_o,      32'hB001A001);
    check("t4_head_last",  32'(last_o), 32'd0);
`ifdef HYPERBUS_RX_ERR_CNT_EN
    check("t4_err_cnt", 32'(err_cnt_o), 32'd2);
`endif
    ready_i = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("t4_drain_data", data_o,       {16'hB000 + 16'(k), 16'hA000 + 16'(k)});
      check("t4_drain_last", 32'(last_o),  32'd0);
      check("t4_drain_vld",  32'(valid_o), 32'd1);
    end
    tick();
    check("t4_end_valid", 32'(valid_o),    32'd0);
    check("t4_end_busy",  32'(busy_o),     32'd0);
    check("t4_end_ovf",   32'(overflow_o), 32'd1);

    // 5: zero-length start, ignored data in IDLE, start ignored while busy
    start(16'd0);
    check("t5_busy0",  32'(busy_o),     32'd0);
    check("t5_ovf_clr", 32'(overflow_o), 32'd0);
`ifdef HYPERBUS_RX_ERR_CNT_EN
    check("t5_err_clr", 32'(err_cnt_o), 32'd0);
`endif
    send_raw(to_ddr(16'h9999));
    send_raw(to_ddr(16'h6666));
    check("t5_idle_valid", 32'(valid_o), 32'd0);
    check("t5_idle_busy",  32'(busy_o),  32'd0);
    start(16'd1);
    send_raw(to_ddr(16'h7777));
    start_i     = 1'b1;
    burst_len_i = 16'd5;
    send_raw(to_ddr(16'h8888));
    start_i     = 1'b0;
    burst_len_i = 16'h0000;
    check("t5_data", data_o,      32'h88887777);
    check("t5_last", 32'(last_o), 32'd1);
    tick();
    check("t5_end_busy",  32'(busy_o),  32'd0);
    check("t5_end_valid", 32'(valid_o), 32'd0);

    // 6: full FIFO with a pop on the same edge as a push
    ready_i = 1'b0;
    start(16'd5);
    for (int k = 1; k <= 4; k++) begin
      send_raw(to_ddr(16'hC000 + 16'(k)));
      send_raw(to_ddr(16'hD000 + 16'(k)));
    end
    check("t6_full_head", data_o, 32'hD001C001);
    send_raw(to_ddr(16'hC005));
    ready_i = 1'b1;
    send_raw(to_ddr(16'hD005));
    check("t6_ovf",  32'(overflow_o), 32'd0);
    check("t6_head", data_o,          32'hD002C002);
    for (int k = 3; k <= 5; k++) begin
      tick();
      check("t6_data", data_o,      {16'hD000 + 16'(k), 16'hC000 + 16'(k)});
      check("t6_last", 32'(last_o), (k == 5) ? 32'd1 : 32'd0);
    end
    tick();
    check("t6_end_valid", 32'(valid_o),    32'd0);
    check("t6_end_busy",  32'(busy_o),     32'd0);
    check("t6_end_ovf",   32'(overflow_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
